// File: rtl/ctrl_pkg.sv
// rtl/ctrl_pkg.sv - shared constants and state encoding for the multicycle control stage
package ctrl_pkg;

   localparam int          OPW      = 4;
   localparam logic [15:0] NOP_WORD = 16'hF000;

   localparam logic [2:0] S_FETCH  = 3'd0;
   localparam logic [2:0] S_DECODE = 3'd1;
   localparam logic [2:0] S_EXEC   = 3'd2;
   localparam logic [2:0] S_MEM    = 3'd3;
   localparam logic [2:0] S_WB     = 3'd4;
   localparam logic [2:0] S_HALT   = 3'd5;

   typedef enum logic [2:0] {
      ST_FETCH  = S_FETCH,
      ST_DECODE = S_DECODE,
      ST_EXEC   = S_EXEC,
      ST_MEM    = S_MEM,
      ST_WB     = S_WB
`ifdef CTRL_HALT_EN
      ,
      ST_HALT   = S_HALT
`endif
   } state_t;

   localparam logic [OPW-1:0] OP_LW   = 4'h8;
   localparam logic [OPW-1:0] OP_SW   = 4'h9;
   localparam logic [OPW-1:0] OP_BEQ  = 4'hA;
   localparam logic [OPW-1:0] OP_JMP  = 4'hB;
   localparam logic [OPW-1:0] OP_HALT = 4'hE;

   localparam logic [1:0] PCSRC_SEQ    = 2'b00;
   localparam logic [1:0] PCSRC_BRANCH = 2'b01;
   localparam logic [1:0] PCSRC_JUMP   = 2'b10;

   localparam logic [2:0] ALUOP_ADD = 3'b000;
   localparam logic [2:0] ALUOP_SUB = 3'b001;

endpackage

// File: rtl/instr_decoder.sv
// rtl/instr_decoder.sv - combinational opcode-to-class decode of the instruction register
// o_is_halt exists only when CTRL_HALT_EN is defined.
module instr_decoder
   import ctrl_pkg::*;
(
   input  logic [OPW-1:0] i_opcode,
   output logic           o_is_rtype,
   output logic           o_is_lw,
   output logic           o_is_sw,
   output logic           o_is_beq,
   output logic           o_is_jmp
`ifdef CTRL_HALT_EN
   ,
   output logic           o_is_halt
`endif
);

   // 0x0-0x7 are all ALU register ops; the MSB alone separates them
   assign o_is_rtype = ~i_opcode[OPW-1];
   assign o_is_lw    = (i_opcode == OP_LW);
   assign o_is_sw    = (i_opcode == OP_SW);
   assign o_is_beq   = (i_opcode == OP_BEQ);
   assign o_is_jmp   = (i_opcode == OP_JMP);
`ifdef CTRL_HALT_EN
   assign o_is_halt  = (i_opcode == OP_HALT);
`endif

endmodule

// File: rtl/control_decode_fsm.sv
// rtl/control_decode_fsm.sv - multicycle FETCH/DECODE/EXEC/MEM/WB controller feeding the register file
// Define CTRL_HALT_EN to add the HALT state (opcode 0xE) and the halted output.
module control_decode_fsm
   import ctrl_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic [15:0] D_Instr,
   input  logic        D_InstrValid,
   input  logic        D_MemReady,
   input  logic        D_ALUZero,
   output logic        C_InstrReq,
   output logic [3:0]  A_ReadReg1RT,
   output logic [3:0]  A_ReadReg2RT,
   output logic [3:0]  A_Offset,
   output logic [3:0]  A_RegSWLW,
   output logic [3:0]  A_WriteRegRT_BT,
   output logic        C_RegDstWrite,
   output logic        C_RegWrite,
   output logic        C_MemToReg,
   output logic        C_MemRead,
   output logic        C_MemWrite,
   output logic [2:0]  C_ALUOp,
   output logic        C_ALUSrc,
   output logic        C_PCWrite,
   output logic [1:0]  C_PCSrc
`ifdef CTRL_HALT_EN
   ,
   output logic        halted
`endif
);

   state_t      r_state;
   state_t      w_next;
   logic [15:0] r_ir;

   logic w_is_rtype;
   logic w_is_lw;
   logic w_is_sw;
   logic w_is_beq;
   logic w_is_jmp;
`ifdef CTRL_HALT_EN
   logic w_is_halt;
`endif

   instr_decoder u_dec (
      .i_opcode   (r_ir[15:12]),
      .o_is_rtype (w_is_rtype),
      .o_is_lw    (w_is_lw),
      .o_is_sw    (w_is_sw),
      .o_is_beq   (w_is_beq),
      .o_is_jmp   (w_is_jmp)
`ifdef CTRL_HALT_EN
      ,
      .o_is_halt  (w_is_halt)
`endif
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= ST_FETCH;
         r_ir    <= NOP_WORD;
      end else begin
         r_state <= w_next;
         if (r_state == ST_FETCH && D_InstrValid)
            r_ir <= D_Instr;
      end
   end

   // Register-file fields are plain IR slices, so they only move on an IR load
   assign A_ReadReg1RT    = r_ir[7:4];
   assign A_ReadReg2RT    = r_ir[3:0];
   assign A_Offset        = r_ir[3:0];
   assign A_RegSWLW       = r_ir[11:8];
   assign A_WriteRegRT_BT = r_ir[11:8];

`ifdef CTRL_HALT_EN
   assign halted = (r_state == ST_HALT);
`endif

   always_comb begin
      w_next        = r_state;
      C_InstrReq    = 1'b0;
      C_RegDstWrite = 1'b0;
      C_RegWrite    = 1'b0;
      C_MemToReg    = 1'b0;
      C_MemRead     = 1'b0;
      C_MemWrite    = 1'b0;
      C_ALUOp       = ALUOP_ADD;
      C_ALUSrc      = 1'b0;
      C_PCWrite     = 1'b0;
      C_PCSrc       = PCSRC_SEQ;

      case (r_state)
         ST_FETCH: begin
            C_InstrReq = 1'b1;
            if (D_InstrValid) begin
               C_PCWrite = 1'b1;
               w_next    = ST_DECODE;
            end
         end
         ST_DECODE: w_next = ST_EXEC;
         ST_EXEC: begin
            w_next = ST_FETCH;
            if (w_is_rtype) begin
               C_ALUOp = r_ir[14:12];
               w_next  = ST_WB;
            end else if (w_is_lw || w_is_sw) begin
               C_ALUSrc = 1'b1;
               C_ALUOp  = ALUOP_ADD;
               w_next   = ST_MEM;
            end else if (w_is_beq) begin
               C_ALUOp = ALUOP_SUB;
               if (D_ALUZero) begin
                  C_PCWrite = 1'b1;
                  C_PCSrc   = PCSRC_BRANCH;
               end
            end else if (w_is_jmp) begin
               C_PCWrite = 1'b1;
               C_PCSrc   = PCSRC_JUMP;
            end
`ifdef CTRL_HALT_EN
            else if (w_is_halt) begin
               w_next = ST_HALT;
            end
`endif
         end
         ST_MEM: begin
            // Strobe is held until the memory acknowledges; LW and SW are exclusive
            C_MemRead  = w_is_lw;
            C_MemWrite = w_is_sw;
            if (D_MemReady)
               w_next = w_is_lw ? ST_WB : ST_FETCH;
         end
         ST_WB: begin
            C_RegWrite    = 1'b1;
            C_RegDstWrite = w_is_lw;
            C_MemToReg    = w_is_lw;
            w_next        = ST_FETCH;
         end
`ifdef CTRL_HALT_EN
         ST_HALT: w_next = ST_HALT;
`endif
         default: w_next = ST_FETCH;
      endcase
   end

endmodule

// File: tb/tb_control_decode_fsm.sv
// tb/tb_control_decode_fsm.sv - scoreboard bench for control_decode_fsm
// Stimulus pushes expected strobe events (with cycle stamps); a negedge monitor pops and compares.
module tb_control_decode_fsm;

   typedef struct packed {
      logic       req;
      logic [3:0] rr1;
      logic [3:0] rr2;
      logic [3:0] off;
      logic [3:0] swlw;
      logic [3:0] wrt;
      logic       dst;
      logic       rw;
      logic       m2r;
      logic       mr;
      logic       mw;
      logic [2:0] aluop;
      logic       alusrc;
      logic       pcw;
      logic [1:0] pcsrc;
   } snap_t;

   typedef struct {
      snap_t s;
      int    cyc;
   } ev_t;

   logic        clk;
   logic        rst;
   logic [15:0] D_Instr;
   logic        D_InstrValid;
   logic        D_MemReady;
   logic        D_ALUZero;
   logic        C_InstrReq;
   logic [3:0]  A_ReadReg1RT;
   logic [3:0]  A_ReadReg2RT;
   logic [3:0]  A_Offset;
   logic [3:0]  A_RegSWLW;
   logic [3:0]  A_WriteRegRT_BT;
   logic        C_RegDstWrite;
   logic        C_RegWrite;
   logic        C_MemToReg;
   logic        C_MemRead;
   logic        C_MemWrite;
   logic [2:0]  C_ALUOp;
   logic        C_ALUSrc;
   logic        C_PCWrite;
   logic [1:0]  C_PCSrc;
`ifdef CTRL_HALT_EN
   logic        halted;
`endif

   control_decode_fsm dut (
      .clk             (clk),
      .rst             (rst),
      .D_Instr         (D_Instr),
      .D_InstrValid    (D_InstrValid),
      .D_MemReady      (D_MemReady),
      .D_ALUZero       (D_ALUZero),
      .C_InstrReq      (C_InstrReq),
      .A_ReadReg1RT    (A_ReadReg1RT),
      .A_ReadReg2RT    (A_ReadReg2RT),
      .A_Offset        (A_Offset),
      .A_RegSWLW       (A_RegSWLW),
      .A_WriteRegRT_BT (A_WriteRegRT_BT),
      .C_RegDstWrite   (C_RegDstWrite),
      .C_RegWrite      (C_RegWrite),
      .C_MemToReg      (C_MemToReg),
      .C_MemRead       (C_MemRead),
      .C_MemWrite      (C_MemWrite),
      .C_ALUOp         (C_ALUOp),
      .C_ALUSrc        (C_ALUSrc),
      .C_PCWrite       (C_PCWrite),
      .C_PCSrc         (C_PCSrc)
`ifdef CTRL_HALT_EN
      ,
      .halted          (halted)
`endif
   );

   ev_t         sb[$];
   ev_t         mon_ev;
   int          n_chk = 0;
   int          n_fail = 0;
   int          cyc = 0;
   logic [15:0] prev_ir;
   snap_t       w_act;
   logic        w_trig;

   assign w_act = {C_InstrReq, A_ReadReg1RT, A_ReadReg2RT, A_Offset, A_RegSWLW, A_WriteRegRT_BT,
                   C_RegDstWrite, C_RegWrite, C_MemToReg, C_MemRead, C_MemWrite,
                   C_ALUOp, C_ALUSrc, C_PCWrite, C_PCSrc};
   assign w_trig = C_PCWrite | C_RegWrite | C_MemRead | C_MemWrite | C_ALUSrc |
                   C_RegDstWrite | C_MemToReg | (C_ALUOp != 3'd0) | (C_PCSrc != 2'd0);

   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, required completion");
      $fatal(1, "watchdog");
   end

   always @(negedge clk) begin
      if (!rst && w_trig) begin
         n_chk++;
         if (sb.size() == 0) begin
            n_fail++;
            $display("FAIL unexpected_strobe: got %h at cycle %0d, required no strobe", w_act, cyc);
         end else begin
            mon_ev = sb.pop_front();
            if (w_act !== mon_ev.s || cyc != mon_ev.cyc) begin
               n_fail++;
               $display("FAIL sb_event: got %h at cycle %0d, required %h at cycle %0d",
                        w_act, cyc, mon_ev.s, mon_ev.cyc);
            end
         end
      end
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, required %h", nm, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic snap_t base(input logic [15:0] ir);
      snap_t s;
      s      = '0;
      s.rr1  = ir[7:4];
      s.rr2  = ir[3:0];
      s.off  = ir[3:0];
      s.swlw = ir[11:8];
      s.wrt  = ir[11:8];
      return s;
   endfunction

   task automatic push(input snap_t s, input int c);
      ev_t e;
      e.s   = s;
      e.cyc = c;
      sb.push_back(e);
   endtask

   task automatic run_instr(input logic [15:0] ir, input int fw, input int mw, input logic zero);
      int         t;
      snap_t      s;
      logic [3:0] op;
      op = ir[15:12];
      t  = cyc + fw;
      s = base(prev_ir); s.req = 1'b1; s.pcw = 1'b1; push(s, t);
      if (!op[3]) begin
         if (op != 4'd0) begin
            s = base(ir); s.aluop = op[2:0]; push(s, t + 2);
         end
         s = base(ir); s.rw = 1'b1; push(s, t + 3);
      end else if (op == 4'h8 || op == 4'h9) begin
         s = base(ir); s.alusrc = 1'b1; push(s, t + 2);
         for (int i = 0; i <= mw; i++) begin
            s = base(ir);
            if (op == 4'h8) s.mr = 1'b1; else s.mw = 1'b1;
            push(s, t + 3 + i);
         end
         if (op == 4'h8) begin
            s = base(ir); s.rw = 1'b1; s.dst = 1'b1; s.m2r = 1'b1; push(s, t + 4 + mw);
         end
      end else if (op == 4'hA) begin
         s = base(ir); s.aluop = 3'b001;
         if (zero) begin s.pcw = 1'b1; s.pcsrc = 2'b01; end
         push(s, t + 2);
      end else if (op == 4'hB) begin
         s = base(ir); s.pcw = 1'b1; s.pcsrc = 2'b10; push(s, t + 2);
      end

      D_ALUZero    = zero;
      D_InstrValid = 1'b0;
      D_MemReady   = 1'b1;
      repeat (fw) step();
      if (fw > 0)
         chk("stall_hold", {C_InstrReq, A_RegSWLW, A_ReadReg1RT, A_ReadReg2RT},
             {1'b1, prev_ir[11:0]});
      D_MemReady   = 1'b0;
      D_Instr      = ir;
      D_InstrValid = 1'b1;
      step();
      D_Instr      = 16'h9FFF;
      step();
      D_InstrValid = 1'b0;
      if (op == 4'h8 || op == 4'h9) begin
         step();
         repeat (mw) step();
         D_MemReady = 1'b1;
         step();
         D_MemReady = 1'b0;
         if (op == 4'h8) step();
      end else if (!op[3]) begin
         step();
         step();
      end else begin
         step();
      end
      chk("back_in_fetch", {C_InstrReq, C_PCWrite}, 2'b10);
      prev_ir = ir;
   endtask

   initial begin
      int    c0;
      snap_t s;
      rst          = 1'b1;
      D_Instr      = 16'h0000;
      D_InstrValid = 1'b0;
      D_MemReady   = 1'b0;
      D_ALUZero    = 1'b0;
      prev_ir      = 16'hF000;
      #1;
      chk("rst_req", C_InstrReq, 1);
      chk("rst_strobes", {C_RegDstWrite, C_RegWrite, C_MemToReg, C_MemRead, C_MemWrite,
                          C_ALUOp, C_ALUSrc, C_PCWrite, C_PCSrc}, 0);
      chk("rst_ir_fields", {A_RegSWLW, A_ReadReg1RT, A_ReadReg2RT}, 0);
      step();
      step();
      rst = 1'b0;

      run_instr(16'h0321, 0, 0, 1'b0);
      run_instr(16'h5ABC, 0, 0, 1'b0);
      run_instr(16'h8574, 0, 3, 1'b0);
      run_instr(16'h9A20, 0, 2, 1'b0);
      run_instr(16'hA123, 0, 0, 1'b1);
      run_instr(16'hA456, 0, 0, 1'b0);
      run_instr(16'hB000, 0, 0, 1'b1);
      run_instr(16'hC777, 5, 0, 1'b0);
`ifndef CTRL_HALT_EN
      run_instr(16'hE000, 0, 0, 1'b0);
`endif
      run_instr(16'h8F01, 0, 0, 1'b0);

      // SW abandoned by reset in the second MEM cycle
      c0 = cyc;
      s = base(prev_ir); s.req = 1'b1; s.pcw = 1'b1; push(s, c0);
      s = base(16'h9A20); s.alusrc = 1'b1; push(s, c0 + 2);
      s = base(16'h9A20); s.mw = 1'b1; push(s, c0 + 3);
      D_Instr      = 16'h9A20;
      D_InstrValid = 1'b1;
      D_MemReady   = 1'b0;
      step();
      D_InstrValid = 1'b0;
      step();
      step();
      step();
      rst = 1'b1;
      #1;
      chk("rst_mem_write_drop", {C_MemWrite, C_MemRead, C_PCWrite}, 0);
      chk("rst_mid_req", C_InstrReq, 1);
      chk("rst_mid_ir", {A_RegSWLW, A_ReadReg1RT, A_ReadReg2RT}, 0);
      D_MemReady = 1'b1;
      step();
      step();
      rst        = 1'b0;
      D_MemReady = 1'b0;
      chk("post_rst_fetch", C_InstrReq, 1);
      prev_ir = 16'hF000;
      run_instr(16'h7DEF, 0, 0, 1'b0);

`ifdef CTRL_HALT_EN
      c0 = cyc;
      s = base(prev_ir); s.req = 1'b1; s.pcw = 1'b1; push(s, c0);
      D_Instr      = 16'hE000;
      D_InstrValid = 1'b1;
      step();
      step();
      step();
      D_MemReady = 1'b1;
      for (int i = 0; i < 20; i++) begin
         chk("halt_flag", {halted, C_InstrReq}, 2'b10);
         step();
      end
      D_InstrValid = 1'b0;
      D_MemReady   = 1'b0;
`endif

      step();
      chk("sb_empty", sb.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
